// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared state encoding and width constants for the RSA modular exponentiator
package rsa_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SQUARE,
      MULT,
      DONE
   } state_t;

   localparam int RSA_WIDTH = 64;
   localparam int RSA_IDX_W = $clog2(RSA_WIDTH);

endpackage

// File: rtl/rsa_modexp_mult.sv
// rtl/rsa_modexp_mult.sv - mod_mult_serial: interleaved shift-add modular multiplier, one bit of b per cycle
module mod_mult_serial #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             go,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] n,
   output logic [WIDTH-1:0] p,
   output logic             rdy
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   // acc is WIDTH+2 bits wide so 2*acc + a < 4n cannot overflow mid-step
   logic [WIDTH+1:0] acc;
   logic [WIDTH+1:0] dbl;
   logic [WIDTH+1:0] sum;
   logic [WIDTH+1:0] n_ext;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_sh;
   logic [CNT_W-1:0] cnt;
   logic             run;

   assign n_ext = {2'b00, n};
   assign p     = acc[WIDTH-1:0];
   assign rdy   = run && (cnt == '0);

   // One MSB-first step: double and reduce, then conditionally add a and reduce
   always_comb begin
      dbl = acc + acc;
      if (dbl >= n_ext) dbl = dbl - n_ext;
      sum = dbl + (b_sh[WIDTH-1] ? {2'b00, a_r} : '0);
      if (sum >= n_ext) sum = sum - n_ext;
   end

   // go reloads operands (also while rdy); otherwise consume one multiplier bit per cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc  <= '0;
         a_r  <= '0;
         b_sh <= '0;
         cnt  <= '0;
         run  <= 1'b0;
      end else if (go) begin
         acc  <= '0;
         a_r  <= a;
         b_sh <= b;
         cnt  <= CNT_W'(WIDTH);
         run  <= 1'b1;
      end else if (run && cnt != '0) begin
         acc  <= sum;
         b_sh <= b_sh << 1;
         cnt  <= cnt - CNT_W'(1);
      end else begin
         run  <= 1'b0;
      end
   end

endmodule

// File: rtl/rsa_modexp.sv
// rtl/rsa_modexp.sv - left-to-right square-and-multiply modexp; RSA_MODEXP_SKIP_LZ_EN skips leading exponent zeros
module rsa_modexp
   import rsa_pkg::*;
#(
   parameter int WIDTH = RSA_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] base,
   input  logic [WIDTH-1:0] exponent,
   input  logic [WIDTH-1:0] modulus,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int IDX_W = (WIDTH == RSA_WIDTH) ? RSA_IDX_W : $clog2(WIDTH);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] base_r, exp_r, mod_r;
   logic [WIDTH-1:0] acc, acc_nxt, result_nxt, acc_one;
   logic [IDX_W-1:0] bit_idx, bit_idx_nxt;
   logic             err_nxt, load_ops;
   logic             mul_go, mul_rdy;
   logic [WIDTH-1:0] mul_a, mul_b, mul_p;

   assign busy    = (state == LOAD) || (state == SQUARE) || (state == MULT);
   assign done    = (state == DONE);
   assign acc_one = (mod_r == WIDTH'(1)) ? '0 : WIDTH'(1);

`ifdef RSA_MODEXP_SKIP_LZ_EN
   logic [IDX_W-1:0] exp_msb;

   // Index of the highest set exponent bit (0 when the exponent is zero)
   always_comb begin
      exp_msb = '0;
      for (int i = 0; i < WIDTH; i++)
         if (exp_r[i]) exp_msb = IDX_W'(i);
   end
`endif

   mod_mult_serial #(.WIDTH(WIDTH)) u_mult (
      .clk     (clk),
      .reset_n (reset_n),
      .go      (mul_go),
      .a       (mul_a),
      .b       (mul_b),
      .n       (mod_r),
      .p       (mul_p),
      .rdy     (mul_rdy)
   );

   // Next state; the multiplier is launched on the cycle leaving the previous state so
   // that SQUARE and MULT each last exactly WIDTH+1 cycles
   always_comb begin
      state_nxt   = state;
      acc_nxt     = acc;
      bit_idx_nxt = bit_idx;
      result_nxt  = result;
      err_nxt     = err;
      load_ops    = 1'b0;
      mul_go      = 1'b0;
      mul_a       = acc;
      mul_b       = acc;
      case (state)
         IDLE: begin
            if (start) begin
               load_ops   = 1'b1;
               result_nxt = '0;
               err_nxt    = 1'b0;
               state_nxt  = LOAD;
            end
         end
         LOAD: begin
            if (mod_r == '0 || base_r >= mod_r) begin
               err_nxt    = 1'b1;
               result_nxt = '0;
               state_nxt  = DONE;
            end else begin
               acc_nxt     = acc_one;
`ifdef RSA_MODEXP_SKIP_LZ_EN
               bit_idx_nxt = exp_msb;
               if (exp_r == '0) begin
                  result_nxt = acc_one;
                  state_nxt  = DONE;
               end else begin
                  mul_go    = 1'b1;
                  mul_a     = acc_one;
                  mul_b     = acc_one;
                  state_nxt = SQUARE;
               end
`else
               bit_idx_nxt = IDX_W'(WIDTH - 1);
               mul_go      = 1'b1;
               mul_a       = acc_one;
               mul_b       = acc_one;
               state_nxt   = SQUARE;
`endif
            end
         end
         SQUARE: begin
            if (mul_rdy) begin
               acc_nxt   = mul_p;
               mul_go    = 1'b1;
               mul_a     = base_r;
               mul_b     = mul_p;
               state_nxt = MULT;
            end
         end
         MULT: begin
            if (mul_rdy) begin
               acc_nxt = exp_r[bit_idx] ? mul_p : acc;
               if (bit_idx == '0) begin
                  result_nxt = acc_nxt;
                  state_nxt  = DONE;
               end else begin
                  bit_idx_nxt = bit_idx - IDX_W'(1);
                  mul_go      = 1'b1;
                  mul_a       = acc_nxt;
                  mul_b       = acc_nxt;
                  state_nxt   = SQUARE;
               end
            end
         end
         DONE: begin
            if (!start) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, operand latches and datapath registers; reset aborts any operation in flight
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         base_r  <= '0;
         exp_r   <= '0;
         mod_r   <= '0;
         acc     <= '0;
         bit_idx <= '0;
         result  <= '0;
         err     <= 1'b0;
      end else begin
         state   <= state_nxt;
         acc     <= acc_nxt;
         bit_idx <= bit_idx_nxt;
         result  <= result_nxt;
         err     <= err_nxt;
         if (load_ops) begin
            base_r <= base;
            exp_r  <= exponent;
            mod_r  <= modulus;
         end
      end
   end

endmodule

// File: tb/tb_rsa_modexp.sv
// tb/tb_rsa_modexp.sv - randomized self-checking bench for rsa_modexp against an arithmetic reference model
module tb_rsa_modexp;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         start;
   logic [W-1:0] base, exponent, modulus;
   logic [W-1:0] result;
   logic         busy, done, err;

   int           n_checks = 0;
   int           n_fail   = 0;

   logic [W-1:0] exp_result;
   logic         exp_err;
   int           exp_lat;

   int           cyc;
   bit           prev_busy, prev_done;

   rsa_modexp #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .base     (base),
      .exponent (exponent),
      .modulus  (modulus),
      .result   (result),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Right-to-left binary exponentiation with native arithmetic
   function automatic logic [W-1:0] model(input logic [W-1:0] b, input logic [W-1:0] e,
                                          input logic [W-1:0] n);
      longint unsigned r, x, k;
      if (n == 0 || b >= n) return '0;
      r = 64'(1) % 64'(n);
      x = 64'(b);
      k = 64'(e);
      while (k != 0) begin
         if (k[0]) r = (r * x) % 64'(n);
         x = (x * x) % 64'(n);
         k = k >> 1;
      end
      return W'(r);
   endfunction

   function automatic int model_lat(input logic [W-1:0] e, input logic is_err);
      int msb;
      if (is_err) return 2;
`ifdef RSA_MODEXP_SKIP_LZ_EN
      if (e == 0) return 2;
      msb = 0;
      for (int i = 0; i < W; i++) if (e[i]) msb = i;
      return 2 + (msb + 1) * 2 * (W + 1);
`else
      msb = int'(e[0]);
      return 2 + W * 2 * (W + 1) + msb * 0;
`endif
   endfunction

   // Compare process: latency at the rising edge of done, result/err on every done cycle
   initial begin
      cyc = 0;
      prev_busy = 0;
      prev_done = 0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            cyc = 0;
            prev_busy = 0;
            prev_done = 0;
         end else begin
            if (busy && !prev_busy) cyc = 1;
            else if (busy) cyc++;
            if (done) begin
               if (!prev_done) begin
                  cyc++;
                  check("latency", 64'(cyc), 64'(exp_lat));
               end
               check("result", 64'(result), 64'(exp_result));
               check("err", 64'(err), 64'(exp_err));
               check("busy_in_done", 64'(busy), 64'd0);
            end
            prev_busy = busy;
            prev_done = done;
         end
      end
   end

   task automatic run_op(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] n,
                         input bit hold);
      int k;
      exp_err    = (n == 0) || (b >= n);
      exp_result = model(b, e, n);
      exp_lat    = model_lat(e, exp_err);
      base       = b;
      exponent   = e;
      modulus    = n;
      start      = 1'b1;
      @(negedge clk);
      check("busy_after_start", 64'(busy), 64'd1);
      if (!hold) start = 1'b0;
      base     = W'($urandom);
      exponent = W'($urandom);
      modulus  = W'($urandom);
      k = 0;
      while (done !== 1'b1 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      check("done_seen", 64'(done), 64'd1);
      if (hold) begin
         repeat (5) @(negedge clk);
         check("done_held", 64'(done), 64'd1);
         check("no_restart", 64'(busy), 64'd0);
         start = 1'b0;
      end
      @(negedge clk);
      check("done_pulse_end", 64'(done), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
   endtask

   initial begin
      logic [W-1:0] rn, rb, re;
      reset_n  = 1'b0;
      start    = 1'b0;
      base     = '0;
      exponent = '0;
      modulus  = '0;
      exp_result = '0;
      exp_err    = 1'b0;
      exp_lat    = 0;
      #1;
      check("reset_result", 64'(result), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_err", 64'(err), 64'd0);

      check("pin_445", 64'(model(16'd4, 16'd13, 16'd497)), 64'd445);
      check("pin_2790", 64'(model(16'd65, 16'd17, 16'd3233)), 64'd2790);
      check("pin_65", 64'(model(16'd2790, 16'd2753, 16'd3233)), 64'd65);
      check("pin_exp0", 64'(model(16'd5, 16'd0, 16'd11)), 64'd1);
      check("pin_mod1", 64'(model(16'd0, 16'd9, 16'd1)), 64'd0);
`ifdef RSA_MODEXP_SKIP_LZ_EN
      check("pin_lat", 64'(model_lat(16'd13, 1'b0)), 64'd138);
`else
      check("pin_lat", 64'(model_lat(16'd13, 1'b0)), 64'd546);
`endif

      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      run_op(16'd4, 16'd13, 16'd497, 1'b0);
      run_op(16'd65, 16'd17, 16'd3233, 1'b0);
      run_op(16'd2790, 16'd2753, 16'd3233, 1'b1);
      run_op(16'd5, 16'd7, 16'd0, 1'b0);
      run_op(16'd12, 16'd7, 16'd11, 1'b0);
      run_op(16'd3, 16'd0, 16'd11, 1'b0);
      run_op(16'd0, 16'd5, 16'd1, 1'b0);
      run_op(16'd10, 16'd0, 16'd11, 1'b1);

      base     = 16'd4;
      exponent = 16'd13;
      modulus  = 16'd497;
      start    = 1'b1;
      repeat (200) @(negedge clk);
      check("busy_before_abort", 64'(busy), 64'd1);
      reset_n = 1'b0;
      start   = 1'b0;
      #1;
      check("abort_result", 64'(result), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_err", 64'(err), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      run_op(16'd4, 16'd13, 16'd497, 1'b0);

      for (int i = 0; i < 6; i++) begin
         rn = W'($urandom_range(2, 65535));
         rb = W'($urandom % 32'(rn));
         re = W'($urandom);
         run_op(rb, re, rn, (i % 3) == 2);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
